data_bus_arbiter: RTL
=====================

DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, maximum accepted-but-unanswered transactions (1..4).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 m0_req, m1_req  in  1  requester 0 (LSU) / requester 1 (debug/DMA) request.
REQ-006 m0_we, m1_we  in  1  write enable per requester.
REQ-007 m0_addr, m1_addr  in  ADDR_W  address per requester.
REQ-008 m0_wdata, m1_wdata  in  32  write data per requester.
REQ-009 m0_gnt, m1_gnt  out  1  grant per requester.
REQ-010 m0_rvalid, m1_rvalid  out  1  response valid per requester.
REQ-011 m_rdata  out  32  response data, shared by both requesters.
REQ-012 data_req, data_we, data_addr, data_wdata  out  1/1/ADDR_W/32  memory-side request.
REQ-013 data_gnt, data_rvalid  in  1  memory-side grant / response valid.
REQ-014 data_rdata  in  32  memory-side response data.
REQ-015 resp_err  out  1  sticky: data_rvalid arrived with no transaction outstanding.

Function
REQ-016 data_req SHALL be high when (m0_req|m1_req) and outstanding count < MAX_OUTSTANDING; data_we/addr/wdata SHALL come combinationally from the selected requester.
REQ-017 Accepted transaction SHALL be the cycle data_req & data_gnt; only the selected requester sees mN_gnt = data_gnt in that cycle; the other's gnt SHALL be 0.
REQ-018 Lock: if data_req high and data_gnt low, selection SHALL be held until accepted, regardless of the other requester's req.
REQ-019 On acceptance, owner ID SHALL be pushed into an owner FIFO of depth MAX_OUTSTANDING; count +1.
REQ-020 On data_rvalid with count>0, the FIFO head SHALL be popped; count -1; mN_rvalid of the owner high that same cycle (0-cycle response latency); m_rdata = data_rdata always.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged and keep FIFO order.
REQ-022 When count == MAX_OUTSTANDING, data_req SHALL be 0, even if data_rvalid is high that cycle.
REQ-023 data_rvalid with count==0 SHALL set resp_err, pop nothing, and raise no mN_rvalid.
REQ-024 FIFO read/write pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-025 Acceptance latency: request to data_req 0 cycles; no bubble between back-to-back accepted transactions.

Reset
REQ-026 rst_n low SHALL immediately clear count, FIFO pointers, lock, and resp_err; last_grant SHALL reset to 1 (m0 wins first tie); all gnt/rvalid/data_req outputs 0.
REQ-027 Transactions outstanding at reset SHALL be discarded; later stray data_rvalid SHALL set resp_err.

Configuration
REQ-028 With DBUS_ARB_RR_EN defined: round-robin; on tie, the requester not granted last wins; last_grant updates on acceptance only.
REQ-029 Without DBUS_ARB_RR_EN: fixed priority, m0 always wins ties; last_grant logic absent.

Structure
REQ-030 Shared package SHALL hold requester ID type (1-bit, M0=0, M1=1) and MAX_OUTSTANDING bound constant.
REQ-031 Owner FIFO SHALL be a sub-module arb_owner_fifo (push, pop, id in/out, count, full, empty).

Verification
REQ-032 m0_req only, addr 0x100, data_gnt=1, data_rvalid next cycle rdata 0xDEADBEEF -> m0_gnt cycle 0, m0_rvalid cycle 1, m_rdata 0xDEADBEEF.
REQ-033 Both req, RR enabled, 4 back-to-back accepts -> grants m0,m1,m0,m1; without macro -> m0 x4.
REQ-034 m1 selected, data_gnt low 3 cycles, m0_req raised cycle 1 -> data_addr stays m1_addr until gnt; m1_gnt on cycle 3.
REQ-035 MAX_OUTSTANDING=2, two accepts, no rvalid -> data_req 0; one rvalid -> data_req 1 next cycle; responses routed in order.
REQ-036 data_rvalid with count 0 -> resp_err 1 until rst_n low; no mN_rvalid.
REQ-037 rst_n low with 2 outstanding -> count 0 immediately; subsequent rvalid sets resp_err.

Source files
------------

// File: rtl/data_bus_arbiter_pkg.sv
// Shared types and bounds for the two-requester data bus arbiter.
package data_bus_arbiter_pkg;

  typedef enum logic {
    REQ_M0 = 1'b0,
    REQ_M1 = 1'b1
  } req_id_t;

  typedef enum logic {
    LOCK_OPEN = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_t;

  localparam int unsigned MAX_OUTSTANDING_BOUND = 4;
  localparam int unsigned CNT_W                 = 3;

endpackage

// File: rtl/arb_owner_fifo.sv
// Owner-ID FIFO recording which requester each in-flight transaction belongs to.
module arb_owner_fifo
  import data_bus_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  req_id_t          i_id,
  output req_id_t          o_id,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [1:0]       LAST_IDX = 2'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Storage is always sized to the bound so the 2-bit pointers index it exactly.
  req_id_t          r_mem [MAX_OUTSTANDING_BOUND];
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_id      = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? 2'd0 : r_wr_ptr + 2'd1;
      if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? 2'd0 : r_rd_ptr + 2'd1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-requester data bus arbiter with outstanding-transaction tracking.
// Define DBUS_ARB_RR_EN for round-robin tie-break; default is fixed m0 priority.
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [31:0]       m_rdata,
  output logic              data_req,
  output logic              data_we,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_gnt,
  input  logic              data_rvalid,
  input  logic [31:0]       data_rdata,
  output logic              resp_err
);

  lock_state_t      r_lock_state, w_lock_next;
  req_id_t          r_lock_id, w_lock_id_next;
  req_id_t          w_sel;
  req_id_t          w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_pop;
  logic             r_resp_err;

`ifdef DBUS_ARB_RR_EN
  req_id_t          r_last_grant;
`endif

  always_comb begin
    w_sel = REQ_M0;
    if (r_lock_state == LOCK_HELD) begin
      w_sel = r_lock_id;
    end else if (m0_req && m1_req) begin
`ifdef DBUS_ARB_RR_EN
      w_sel = (r_last_grant == REQ_M0) ? REQ_M1 : REQ_M0;
`else
      w_sel = REQ_M0;
`endif
    end else if (m1_req) begin
      w_sel = REQ_M1;
    end
  end

  // Gated by rst_n so the request drops the instant reset asserts.
  assign data_req   = rst_n & (m0_req | m1_req) & ~w_full;
  assign data_we    = (w_sel == REQ_M1) ? m1_we    : m0_we;
  assign data_addr  = (w_sel == REQ_M1) ? m1_addr  : m0_addr;
  assign data_wdata = (w_sel == REQ_M1) ? m1_wdata : m0_wdata;

  assign w_accept  = data_req & data_gnt;
  assign m0_gnt    = w_accept & (w_sel == REQ_M0);
  assign m1_gnt    = w_accept & (w_sel == REQ_M1);

  assign w_pop     = data_rvalid & ~w_empty;
  assign m0_rvalid = w_pop & (w_head == REQ_M0);
  assign m1_rvalid = w_pop & (w_head == REQ_M1);
  assign m_rdata   = data_rdata;
  assign resp_err  = r_resp_err;

  always_comb begin
    w_lock_next    = LOCK_OPEN;
    w_lock_id_next = r_lock_id;
    if (data_req && !data_gnt) begin
      w_lock_next    = LOCK_HELD;
      w_lock_id_next = w_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_state <= LOCK_OPEN;
      r_lock_id    <= REQ_M0;
      r_resp_err   <= 1'b0;
    end else begin
      r_lock_state <= w_lock_next;
      r_lock_id    <= w_lock_id_next;
      if (data_rvalid && (w_count == '0)) r_resp_err <= 1'b1;
    end
  end

`ifdef DBUS_ARB_RR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_last_grant <= REQ_M1;
    else if (w_accept) r_last_grant <= w_sel;
  end
`endif

  arb_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_accept),
    .i_pop   (w_pop),
    .i_id    (w_sel),
    .o_id    (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule
